bf_tape_ctrl: RTL and testbench

Sequencer for the BF machine's data-tape RAM (single-port, synchronous read, 1-cycle read latency, write on wren). It accepts one tape operation at a time from the instruction decoder and owns the data pointer. It performs read-modify-write on the current cell and runs the byte I/O handshakes for '.' and ','. After reset it zero-sweeps the whole RAM, because the RAM has no reset of its own, and it exports a zero flag so the decoder can resolve '[' and ']'.

---
 rtl/bf_pkg.sv | 26 ++
 rtl/bf_tape_ctrl.sv | 160 ++++++++++++++++
 tb/tb_bf_tape_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bf_pkg.sv
// Shared constants for the BF machine: default widths, tape op encodings
// and the tape controller state encoding.
package bf_pkg;

  localparam int DAW_DEF = 8;
  localparam int DOW_DEF = 8;

  localparam logic [2:0] OP_INC   = 3'd0;
  localparam logic [2:0] OP_DEC   = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_OUT   = 3'd4;
  localparam logic [2:0] OP_IN    = 3'd5;
  localparam logic [2:0] OP_NOP   = 3'd6;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_FETCH = 3'd2,
    ST_LOAD  = 3'd3,
    ST_OWAIT = 3'd4,
    ST_IWAIT = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/bf_tape_ctrl.sv
// Data-tape sequencer: owns the data pointer, caches the current cell,
// performs read-modify-write and byte I/O handshakes, and zero-sweeps the
// tape RAM after every reset since the RAM itself has no reset.
module bf_tape_ctrl
  import bf_pkg::*;
#(
  parameter int DAW = DAW_DEF,
  parameter int DOW = DOW_DEF
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     cmd_op,
  output logic           done,
  output logic           cell_zero,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DOW-1:0] out_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DOW-1:0] in_data,
  output logic [DAW-1:0] mem_address,
  output logic [DOW-1:0] mem_data,
  output logic           mem_wren,
  input  logic [DOW-1:0] mem_q,
  output logic           clearing
);

  localparam logic [DOW-1:0] D_ZERO   = {DOW{1'b0}};
  localparam logic [DOW-1:0] D_ONE    = {{(DOW-1){1'b0}}, 1'b1};
  localparam logic [DAW-1:0] A_ONE    = {{(DAW-1){1'b0}}, 1'b1};
  localparam logic [DAW:0]   C_ONE    = {{DAW{1'b0}}, 1'b1};
  localparam logic [DAW:0]   C_LAST   = {1'b0, {DAW{1'b1}}};

  state_t         state, state_nx;
  logic [DAW-1:0] ptr, ptr_nx;
  logic [DOW-1:0] cur, cur_nx;
  logic [DAW:0]   clr_cnt, clr_nx;
  logic           wren;

  // The cached cell drives the OUT port and the zero flag directly.
  assign out_data  = cur;
  assign cell_zero = (cur == D_ZERO);
  // No write reaches the RAM while reset is held; the sweep starts on release.
  assign mem_wren  = wren & ~reset;

  // State, pointer, cache and sweep counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_CLEAR;
      ptr     <= {DAW{1'b0}};
      cur     <= D_ZERO;
      clr_cnt <= {(DAW+1){1'b0}};
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      cur     <= cur_nx;
      clr_cnt <= clr_nx;
    end
  end

  // Next-state, register updates and RAM/handshake outputs per state.
  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    cur_nx      = cur;
    clr_nx      = clr_cnt;
    cmd_ready   = 1'b0;
    done        = 1'b0;
    out_valid   = 1'b0;
    in_ready    = 1'b0;
    clearing    = 1'b0;
    mem_address = ptr;
    mem_data    = cur;
    wren        = 1'b0;
    case (state)
      ST_CLEAR: begin
        clearing    = 1'b1;
        mem_address = clr_cnt[DAW-1:0];
        mem_data    = D_ZERO;
        wren        = 1'b1;
        clr_nx      = clr_cnt + C_ONE;
        // The last address is written on this cycle, so leave now.
        if (clr_cnt == C_LAST) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            OP_INC: begin
              wren     = 1'b1;
              mem_data = cur + D_ONE;
              cur_nx   = cur + D_ONE;
              state_nx = ST_DONE;
            end
            OP_DEC: begin
              wren     = 1'b1;
              mem_data = cur - D_ONE;
              cur_nx   = cur - D_ONE;
              state_nx = ST_DONE;
            end
            OP_RIGHT: begin
              ptr_nx   = ptr + A_ONE;
              state_nx = ST_FETCH;
            end
            OP_LEFT: begin
              ptr_nx   = ptr - A_ONE;
              state_nx = ST_FETCH;
            end
            OP_OUT:  state_nx = ST_OWAIT;
            OP_IN:   state_nx = ST_IWAIT;
            default: state_nx = ST_DONE;
          endcase
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // mem_address already carries the updated pointer.
        state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        cur_nx   = mem_q;
        state_nx = ST_DONE;
      end
      ST_OWAIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_OWAIT;
        end
      end
      ST_IWAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wren     = 1'b1;
          mem_data = in_data;
          cur_nx   = in_data;
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_IWAIT;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_CLEAR;
      end
    endcase
  end

endmodule

// File: tb/tb_bf_tape_ctrl.sv
// Directed testbench for bf_tape_ctrl with a behavioural tape RAM model.
module tb_bf_tape_ctrl;
  import bf_pkg::*;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic       done;
  logic       cell_zero;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] mem_address;
  logic [7:0] mem_data;
  logic       mem_wren;
  logic [7:0] mem_q;
  logic       clearing;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int acc_cnt = 0;
  int d0, w0, a0;

  logic [7:0] ram [0:255];

  bf_tape_ctrl #(.DAW(8), .DOW(8)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .done(done), .cell_zero(cell_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .clearing(clearing)
  );

  // Free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single-port synchronous RAM plus event counters.
  always @(posedge clock) begin
    if (mem_wren) begin
      ram[mem_address] <= mem_data;
      wr_cnt <= wr_cnt + 1;
    end
    mem_q <= ram[mem_address];
    if (done) done_cnt <= done_cnt + 1;
    if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge where reset has just dropped.
  task automatic sweep_check();
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      #1;
      if (!(mem_wren === 1'b1 && mem_address === i[7:0] && mem_data === 8'd0 &&
            clearing === 1'b1 && cmd_ready === 1'b0)) bad++;
      @(negedge clock);
    end
    check("sweep_bad_cycles", bad, 0);
    #1;
    check("post_sweep_ready", cmd_ready, 1);
    check("post_sweep_clearing", clearing, 0);
    check("post_sweep_wren", mem_wren, 0);
  endtask

  // Single-cycle op (INC/DEC/NOP/reserved): accept cycle then DONE cycle.
  task automatic simple_op(input logic [2:0] op, input logic exp_wren,
                           input logic [7:0] exp_wdata, input logic [7:0] exp_ptr,
                           input logic [7:0] exp_cur);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = op;
    #1;
    check("op_accept_ready", cmd_ready, 1);
    check("op_accept_wren", mem_wren, exp_wren);
    check("op_accept_addr", mem_address, exp_ptr);
    if (exp_wren) check("op_accept_wdata", mem_data, exp_wdata);
    @(negedge clock);
    cmd_valid = 1'b0;
    #1;
    check("op_done", done, 1);
    check("op_done_ready", cmd_ready, 0);
    check("op_done_wren", mem_wren, 0);
    check("op_cur", out_data, exp_cur);
    check("op_zero", cell_zero, (exp_cur == 8'd0) ? 1 : 0);
  endtask

  // RIGHT/LEFT: FETCH, LOAD, DONE, then back to IDLE.
  task automatic move(input logic [2:0] op, input logic [7:0] old_cur,
                      input logic [7:0] exp_ptr, input logic [7:0] exp_cur);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = op;
    #1;
    check("mv_accept_ready", cmd_ready, 1);
    check("mv_accept_wren", mem_wren, 0);
    @(negedge clock);
    cmd_valid = 1'b0;
    #1;
    check("mv_fetch_addr", mem_address, exp_ptr);
    check("mv_fetch_done", done, 0);
    @(negedge clock);
    #1;
    check("mv_load_cur", out_data, old_cur);
    check("mv_load_done", done, 0);
    @(negedge clock);
    #1;
    check("mv_done", done, 1);
    check("mv_cur", out_data, exp_cur);
    check("mv_zero", cell_zero, (exp_cur == 8'd0) ? 1 : 0);
    @(negedge clock);
    #1;
    check("mv_idle_ready", cmd_ready, 1);
    check("mv_idle_ptr", mem_address, exp_ptr);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = 8'd0;

    // Reset state.
    @(negedge clock);
    @(negedge clock);
    #1;
    check("rst_clearing", clearing, 1);
    check("rst_ready", cmd_ready, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_zero", cell_zero, 1);

    // Post-reset sweep.
    @(negedge clock);
    reset = 1'b0;
    sweep_check();
    check("sweep_zero", cell_zero, 1);
    check("sweep_ptr", mem_address, 0);

    // INC x3 then OUT with delayed out_ready.
    simple_op(OP_INC, 1'b1, 8'd1, 8'd0, 8'd1);
    simple_op(OP_INC, 1'b1, 8'd2, 8'd0, 8'd2);
    simple_op(OP_INC, 1'b1, 8'd3, 8'd0, 8'd3);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = OP_OUT;
    #1;
    check("out_accept_wren", mem_wren, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      cmd_valid = 1'b0;
      #1;
      check("owait_valid", out_valid, 1);
      check("owait_data", out_data, 8'd3);
      check("owait_done", done, 0);
    end
    @(negedge clock);
    out_ready = 1'b1;
    #1;
    check("out_hs_valid", out_valid, 1);
    @(negedge clock);
    out_ready = 1'b0;
    #1;
    check("out_done", done, 1);
    check("out_valid_drop", out_valid, 0);

    // Decrement wrap and pointer wrap.
    move(OP_RIGHT, 8'd3, 8'd1, 8'd0);
    simple_op(OP_DEC, 1'b1, 8'd255, 8'd1, 8'd255);
    move(OP_LEFT, 8'd255, 8'd0, 8'd3);
    move(OP_LEFT, 8'd3, 8'd255, 8'd0);
    move(OP_RIGHT, 8'd0, 8'd0, 8'd3);
    move(OP_RIGHT, 8'd3, 8'd1, 8'd255);

    // NOP and reserved op: no write, done next cycle.
    simple_op(OP_NOP, 1'b0, 8'd0, 8'd1, 8'd255);
    simple_op(3'd7, 1'b0, 8'd0, 8'd1, 8'd255);

    // IN with in_valid arriving late.
    w0 = wr_cnt;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = OP_IN;
    #1;
    check("in_accept_ready", cmd_ready, 1);
    @(negedge clock);
    cmd_valid = 1'b0;
    #1;
    check("iwait_ready", in_ready, 1);
    check("iwait_done", done, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #1;
      check("iwait_hold_ready", in_ready, 1);
      check("iwait_hold_wren", mem_wren, 0);
    end
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 8'h41;
    #1;
    check("in_cap_wren", mem_wren, 1);
    check("in_cap_addr", mem_address, 8'd1);
    check("in_cap_data", mem_data, 8'h41);
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    check("in_done", done, 1);
    check("in_cur", out_data, 8'h41);
    check("in_ready_drop", in_ready, 0);
    check("in_write_count", wr_cnt - w0, 1);
    move(OP_RIGHT, 8'h41, 8'd2, 8'd0);
    move(OP_LEFT, 8'd0, 8'd1, 8'h41);

    // Back-pressure: INC held continuously.
    d0 = done_cnt; a0 = acc_cnt; w0 = wr_cnt;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = OP_INC;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("bp_ready_pattern", cmd_ready, ((k % 2) == 0) ? 1 : 0);
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    #1;
    check("bp_accepts", acc_cnt - a0, 4);
    check("bp_dones", done_cnt - d0, 4);
    check("bp_writes", wr_cnt - w0, 4);
    check("bp_cur", out_data, 8'h45);
    check("bp_ready_after", cmd_ready, 1);

    // Reset during OWAIT.
    d0 = done_cnt;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = OP_OUT;
    @(negedge clock);
    cmd_valid = 1'b0;
    #1;
    check("rmid_owait_valid", out_valid, 1);
    check("rmid_owait_data", out_data, 8'h45);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rmid_valid_drop", out_valid, 0);
    check("rmid_clearing", clearing, 1);
    check("rmid_wren", mem_wren, 0);
    check("rmid_ready", cmd_ready, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    sweep_check();
    check("rmid_no_done", done_cnt - d0, 0);
    check("rmid_ptr", mem_address, 8'd0);
    check("rmid_zero", cell_zero, 1);
    move(OP_RIGHT, 8'd0, 8'd1, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
